// File: rtl/match_window_counter_if.sv
// Bus between the windowed match counter and its neighbours: detector pulse and
// enable in, valid/ready count result and overrun flag out.
interface match_window_counter_if #(
    parameter int CNT_W = 5
);
    logic             det_in;
    logic             en;
    logic [CNT_W-1:0] cnt_out;
    logic             sat;
    logic             cnt_valid;
    logic             cnt_ready;
    logic             ovr;

    modport master (
        output det_in, en, cnt_ready,
        input  cnt_out, sat, cnt_valid, ovr
    );

    modport slave (
        input  det_in, en, cnt_ready,
        output cnt_out, sat, cnt_valid, ovr
    );
endinterface

// File: rtl/match_window_counter.sv
// Counts detector match pulses over back-to-back windows of WIN_LEN edges and
// offers each window's saturating count on a valid/ready output register.
module match_window_counter #(
    parameter int WIN_LEN = 16,
    parameter int CNT_W   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    match_window_counter_if.slave  bus
);
    localparam int                 CYC_W    = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
    localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(WIN_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Returns {sat, count}; once the count is pinned at its maximum the sat bit stays set.
    function automatic logic [CNT_W:0] sat_inc(
        input logic [CNT_W-1:0] acc_v,
        input logic             sat_v,
        input logic             hit
    );
        logic [CNT_W:0] r;
        if (hit && (acc_v == CNT_MAX))
            r = {1'b1, acc_v};
        else
            r = {sat_v, acc_v + CNT_W'(hit)};
        return r;
    endfunction

    state_t             state;
    state_t             state_nxt;
    logic               win_end;
    logic               sample;
    logic [CNT_W:0]     res;

    logic [CNT_W-1:0]   acc_p0;
    logic               acc_sat_p0;
    logic [CYC_W-1:0]   cyc_p0;

    logic [CNT_W-1:0]   cnt_p1;
    logic               sat_p1;
    logic               vld_p1;
    logic               ovr_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        win_end   = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.en)
                    state_nxt = RUN;
            end
            RUN: begin
                if (!bus.en) begin
                    state_nxt = IDLE;
                end else begin
                    sample  = 1'b1;
                    win_end = (cyc_p0 == CYC_LAST);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign res = sat_inc(acc_p0, acc_sat_p0, bus.det_in);

    // Stage 0: window accumulator; anything other than a mid-window sample clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p0     <= '0;
            acc_sat_p0 <= 1'b0;
            cyc_p0     <= '0;
        end else if (sample && !win_end) begin
            acc_p0     <= res[CNT_W-1:0];
            acc_sat_p0 <= res[CNT_W];
            cyc_p0     <= cyc_p0 + CYC_W'(1);
        end else begin
            acc_p0     <= '0;
            acc_sat_p0 <= 1'b0;
            cyc_p0     <= '0;
        end
    end

    // Stage 1: output register; a stalled result is never overwritten, the new one is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
            sat_p1 <= 1'b0;
            vld_p1 <= 1'b0;
            ovr_p1 <= 1'b0;
        end else if (win_end) begin
            if (!vld_p1 || bus.cnt_ready) begin
                cnt_p1 <= res[CNT_W-1:0];
                sat_p1 <= res[CNT_W];
                vld_p1 <= 1'b1;
            end else begin
                ovr_p1 <= 1'b1;
            end
        end else if (vld_p1 && bus.cnt_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.cnt_out   = cnt_p1;
    assign bus.sat       = sat_p1;
    assign bus.cnt_valid = vld_p1;
    assign bus.ovr       = ovr_p1;
endmodule
